// File: rtl/dec_wex_bundle_stage.sv
// WEX bundle-parse stage: finds bundle length, routes ops to lanes in reverse order, tags predicates.
// Optional perf counters under JX2_DEC_PERFCNT_EN; 1-cycle latency, valid/ready with 1-entry skid.
module dec_wex_bundle_stage #(
  parameter int NLANE = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [32*NLANE-1:0]  istrWord,
  input  logic                 istrValid,
  output logic                 istrReady,
  input  logic                 srWxe,
  input  logic                 flush,
  input  logic                 idReady,
  output logic                 idValid,
  output logic [32*NLANE-1:0]  idLaneOp,
  output logic [15:0]          idLaneOpHi,
  output logic [NLANE-1:0]     idLaneVal,
  output logic [2*NLANE-1:0]   idLanePred,
  output logic [3:0]           idPcStep,
  output logic                 idBadBndl,
  output logic [31:0]          statBndlCnt,
  output logic [31:0]          statLaneCnt
);

  typedef struct packed {
    logic [32*NLANE-1:0] op;
    logic [15:0]         hi;
    logic [NLANE-1:0]    val;
    logic [2*NLANE-1:0]  pred;
    logic [3:0]          step;
    logic                bad;
    logic [2:0]          n;
  } bndl_t;

  logic [NLANE-1:0] is_e, is_ec, is_f, is_fc, df, wex;
  logic [15:0]      w1_lo;
  bndl_t            nw, outr, skid;
  logic             ov, sv;
  logic             chain, w0_16;
  int               nb, lane;

  // The upper half of a 48-bit op lives in the low half of word 1.
  if (NLANE > 1) begin : g_hi
    assign w1_lo = istrWord[47:32];
  end else begin : g_nohi
    assign w1_lo = '0;
  end

  always_comb begin
    for (int k = 0; k < NLANE; k++) begin
      is_e[k]  = istrWord[32*k+10 +: 6] inside {6'b111000, 6'b111001, 6'b111010};
      is_ec[k] = istrWord[32*k+10 +: 6] == 6'b111011;
      is_f[k]  = istrWord[32*k+10 +: 6] inside {6'b111100, 6'b111101, 6'b111110};
      is_fc[k] = istrWord[32*k+10 +: 6] == 6'b111111;
      case (istrWord[32*k+10 +: 2])
        2'b10:   df[k] = istrWord[32*k+8];
        2'b11:   df[k] = istrWord[32*k+9];
        default: df[k] = istrWord[32*k+10];
      endcase
      wex[k] = df[k] && is_f[k] && srWxe;
    end

    nb    = 1;
    chain = 1'b1;
    for (int k = 0; k < NLANE - 1; k++) begin
      if (chain && wex[k]) nb = nb + 1;
      else                 chain = 1'b0;
    end
    w0_16 = !(is_e[0] || is_ec[0] || is_f[0] || is_fc[0]);

    nw     = '0;
    nw.bad = (NLANE > 1) && chain && wex[NLANE-1];
    nw.n   = 3'(nb);
    lane   = 0;
    for (int j = 0; j < NLANE; j++) begin
      if (j < nb) begin
        lane = nb - 1 - j;
        nw.op[32*lane +: 32] = istrWord[32*j +: 32];
        nw.val[lane] = 1'b1;
        if (is_e[j] || is_ec[j]) nw.pred[2*lane +: 2] = {1'b1, df[j]};
      end
    end

    if (w0_16) begin
      nw.op[31:16] = '0;
      nw.step      = 4'd2;
    end else if (is_ec[0] || is_fc[0]) begin
      nw.hi   = w1_lo;
      nw.step = 4'd6;
    end else begin
      nw.step = 4'(4 * nb);
    end
  end

  // Skid drains into the output register before any new window is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      ov   <= 1'b0;
      sv   <= 1'b0;
      outr <= '0;
      skid <= '0;
    end else if (flush) begin
      ov <= 1'b0;
      sv <= 1'b0;
    end else if (!ov || idReady) begin
      if (sv) begin
        outr <= skid;
        ov   <= 1'b1;
        sv   <= 1'b0;
      end else if (istrValid) begin
        outr <= nw;
        ov   <= 1'b1;
      end else begin
        ov <= 1'b0;
      end
    end else if (istrValid && !sv) begin
      skid <= nw;
      sv   <= 1'b1;
    end
  end

  assign istrReady  = !sv;
  assign idValid    = ov;
  assign idLaneOp   = outr.op;
  assign idLaneOpHi = outr.hi;
  assign idLaneVal  = outr.val;
  assign idLanePred = outr.pred;
  assign idPcStep   = outr.step;
  assign idBadBndl  = outr.bad;

`ifdef JX2_DEC_PERFCNT_EN
  logic [31:0] bndl_cnt, lane_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      bndl_cnt <= '0;
      lane_cnt <= '0;
    end else if (ov && idReady) begin
      bndl_cnt <= bndl_cnt + 32'd1;
      lane_cnt <= lane_cnt + 32'(outr.n);
    end
  end

  assign statBndlCnt = bndl_cnt;
  assign statLaneCnt = lane_cnt;
`else
  assign statBndlCnt = '0;
  assign statLaneCnt = '0;
`endif

endmodule

// File: tb/tb_dec_wex_bundle_stage.sv
// Directed bench for dec_wex_bundle_stage (NLANE=3): parsing, routing, skid ordering, flush, counters.
module tb_dec_wex_bundle_stage;
  logic        clock = 1'b0;
  logic        reset, istrValid, istrReady, srWxe, flush, idReady, idValid, idBadBndl;
  logic [95:0] istrWord, idLaneOp;
  logic [15:0] idLaneOpHi;
  logic [2:0]  idLaneVal;
  logic [5:0]  idLanePred;
  logic [3:0]  idPcStep;
  logic [31:0] statBndlCnt, statLaneCnt;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [31:0] W0  = 32'h1111F400;
  localparam logic [31:0] W1  = 32'h2222F400;
  localparam logic [31:0] W2  = 32'h3333F000;
  localparam logic [31:0] W2B = 32'h3333F400;

  dec_wex_bundle_stage #(.NLANE(3)) dut (
    .clock(clock), .reset(reset), .istrWord(istrWord), .istrValid(istrValid),
    .istrReady(istrReady), .srWxe(srWxe), .flush(flush), .idReady(idReady),
    .idValid(idValid), .idLaneOp(idLaneOp), .idLaneOpHi(idLaneOpHi), .idLaneVal(idLaneVal),
    .idLanePred(idLanePred), .idPcStep(idPcStep), .idBadBndl(idBadBndl),
    .statBndlCnt(statBndlCnt), .statLaneCnt(statLaneCnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bndl(input string tag, input logic [95:0] op, input logic [15:0] hi,
                            input logic [2:0] val, input logic [5:0] pred, input logic [3:0] pcs,
                            input logic bad);
    check({tag, ".vld"},  128'(idValid), 128'(1'b1));
    check({tag, ".op"},   128'(idLaneOp), 128'(op));
    check({tag, ".hi"},   128'(idLaneOpHi), 128'(hi));
    check({tag, ".val"},  128'(idLaneVal), 128'(val));
    check({tag, ".pred"}, 128'(idLanePred), 128'(pred));
    check({tag, ".step"}, 128'(idPcStep), 128'(pcs));
    check({tag, ".bad"},  128'(idBadBndl), 128'(bad));
  endtask

  initial begin
    reset = 1'b1; istrValid = 1'b0; istrWord = '0; srWxe = 1'b1; flush = 1'b0; idReady = 1'b1;
    step(); step();
    check("rst.vld",   128'(idValid), 128'(1'b0));
    check("rst.rdy",   128'(istrReady), 128'(1'b1));
    check("rst.op",    128'(idLaneOp), 128'(0));
    check("rst.step",  128'(idPcStep), 128'(0));
    check("rst.bcnt",  128'(statBndlCnt), 128'(0));
    check("rst.lcnt",  128'(statLaneCnt), 128'(0));
    reset = 1'b0;

    // Back-to-back stream with idReady=1: each window appears the following cycle.
    istrValid = 1'b1; istrWord = {W2, W1, W0}; srWxe = 1'b1;
    step();
    check_bndl("t1", {W0, W1, W2}, 16'h0, 3'b111, 6'b000000, 4'd12, 1'b0);

    srWxe = 1'b0;
    step();
    check_bndl("t2", {64'h0, W0}, 16'h0, 3'b001, 6'b000000, 4'd4, 1'b0);

    srWxe = 1'b1; istrWord = {W2, W1, 32'h5555E400};
    step();
    check_bndl("t3", {64'h0, 32'h5555E400}, 16'h0, 3'b001, 6'b000011, 4'd4, 1'b0);

    istrWord = {W2, W1, 32'hABCD3000};
    step();
    check_bndl("t4a", {64'h0, 32'h00003000}, 16'h0, 3'b001, 6'b000000, 4'd2, 1'b0);

    istrWord = {W2, 32'h99995678, 32'h1234FC00};
    step();
    check_bndl("t4b", {64'h0, 32'h1234FC00}, 16'h5678, 3'b001, 6'b000000, 4'd6, 1'b0);

    istrValid = 1'b0;
    step();
    check("t4.idle", 128'(idValid), 128'(1'b0));

    // Backpressure: X held, Y into skid, Z waits; release must give X, Y, Z in order.
    idReady = 1'b0; istrValid = 1'b1; istrWord = {W2B, W1, W0};
    step();
    check_bndl("t5x", {W0, W1, W2B}, 16'h0, 3'b111, 6'b000000, 4'd12, 1'b1);
    check("t5x.rdy", 128'(istrReady), 128'(1'b1));
    istrWord = {W2, W1, W0};
    step();
    check_bndl("t5x.hold", {W0, W1, W2B}, 16'h0, 3'b111, 6'b000000, 4'd12, 1'b1);
    check("t5.skidfull", 128'(istrReady), 128'(1'b0));
    istrWord = {W2, W1, 32'hABCD3000};
    step();
    check("t5.hold2.op",  128'(idLaneOp), 128'({W0, W1, W2B}));
    check("t5.hold2.rdy", 128'(istrReady), 128'(1'b0));
    idReady = 1'b1;
    step();
    check_bndl("t5y", {W0, W1, W2}, 16'h0, 3'b111, 6'b000000, 4'd12, 1'b0);
    check("t5y.rdy", 128'(istrReady), 128'(1'b1));
    step();
    check_bndl("t5z", {64'h0, 32'h00003000}, 16'h0, 3'b001, 6'b000000, 4'd2, 1'b0);
    istrValid = 1'b0;
    step();
    check("t5.idle", 128'(idValid), 128'(1'b0));
`ifdef JX2_DEC_PERFCNT_EN
    check("t5.bcnt", 128'(statBndlCnt), 128'(8));
    check("t5.lcnt", 128'(statLaneCnt), 128'(14));
`else
    check("t5.bcnt", 128'(statBndlCnt), 128'(0));
    check("t5.lcnt", 128'(statLaneCnt), 128'(0));
`endif

    // Flush with output held and skid full, then with skid empty and a same-cycle input.
    idReady = 1'b0; istrValid = 1'b1; istrWord = {W2, W1, W0};
    step();
    istrWord = {W2B, W1, W0};
    step();
    check("t6.skidfull", 128'(istrReady), 128'(1'b0));
    flush = 1'b1; istrWord = {W2, W1, 32'hABCD3000};
    step();
    check("t6.fl.vld", 128'(idValid), 128'(1'b0));
    check("t6.fl.rdy", 128'(istrReady), 128'(1'b1));
    flush = 1'b0; istrValid = 1'b0;
    step();
    check("t6.noskid", 128'(idValid), 128'(1'b0));
    istrValid = 1'b1; istrWord = {W2, W1, W0};
    step();
    check("t6.reload", 128'(idValid), 128'(1'b1));
    flush = 1'b1; istrWord = {W2, W1, 32'hABCD3000};
    step();
    check("t6.fl2.vld", 128'(idValid), 128'(1'b0));
    flush = 1'b0; istrValid = 1'b0;
    step();
    check("t6.drop", 128'(idValid), 128'(1'b0));
`ifdef JX2_DEC_PERFCNT_EN
    check("t6.bcnt", 128'(statBndlCnt), 128'(8));
    check("t6.lcnt", 128'(statLaneCnt), 128'(14));
`else
    check("t6.bcnt", 128'(statBndlCnt), 128'(0));
    check("t6.lcnt", 128'(statLaneCnt), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
